// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - writeback request, claim and register-file write bundle
//   req_valid/req_ready/req_reg/req_data : per-requester writeback handshake (packed, requester i at slice i)
//   claim_valid/claim_reg               : issue-stage destination claim for the scoreboard
//   ctrl_writeEnable/ctrl_writeReg/data_writeReg : registered register-file write port
//   pending                             : 32-bit pending-write scoreboard
//   grant_idx                           : index of the last accepted requester
//   master: writeback producers + issue stage side; slave: the arbiter
interface regfile_wb_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int IDX_WIDTH  = 3
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic                          claim_valid;
  logic [ADDR_WIDTH-1:0]         claim_reg;
  logic                          ctrl_writeEnable;
  logic [ADDR_WIDTH-1:0]         ctrl_writeReg;
  logic [DATA_WIDTH-1:0]         data_writeReg;
  logic [31:0]                   pending;
  logic [IDX_WIDTH-1:0]          grant_idx;

  modport master (
    output req_valid, req_reg, req_data, claim_valid, claim_reg,
    input  req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, grant_idx
  );

  modport slave (
    input  req_valid, req_reg, req_data, claim_valid, claim_reg,
    output req_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, grant_idx
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin writeback arbiter with pending-write scoreboard
//   clock        : rising-edge clock
//   ctrl_reset_n : asynchronous active-low reset
//   bus (slave)  : writeback requests in, registered register-file write port and scoreboard out
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int IDX_WIDTH  = 3
) (
  input logic                clock,
  input logic                ctrl_reset_n,
  regfile_wb_arbiter_if.slave bus
);

  logic [IDX_WIDTH-1:0]  r_last;
  logic [IDX_WIDTH-1:0]  r_grant_idx;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_wreg;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [31:0]           r_pending;

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_found;
  logic [IDX_WIDTH-1:0]  w_gsel;
  logic [ADDR_WIDTH-1:0] w_sel_reg;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [31:0]           w_set;
  logic [31:0]           w_clr;
  logic [31:0]           w_pending_nxt;

  // Rotating priority: candidates are visited in order last+1 .. last+NUM_REQ,
  // so the most recent winner is considered last.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    w_gsel  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && bus.req_valid[i] && (i == (int'(r_last) + k) % NUM_REQ)) begin
          w_found    = 1'b1;
          w_grant[i] = 1'b1;
          w_gsel     = IDX_WIDTH'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_reg  = bus.req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A claim overrides a same-edge commit: the newer instruction still owes a write.
  // Bit 0 is masked so r0 never looks pending.
  always_comb begin
    w_set         = bus.claim_valid ? (32'd1 << bus.claim_reg) : 32'd0;
    w_clr         = r_we ? (32'd1 << r_wreg) : 32'd0;
    w_pending_nxt = ((r_pending & ~w_clr) | w_set) & ~32'd1;
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_last      <= IDX_WIDTH'(NUM_REQ - 1);
      r_grant_idx <= '0;
      r_we        <= 1'b0;
      r_wreg      <= '0;
      r_wdata     <= '0;
      r_pending   <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      // A write to r0 is accepted from the requester but never strobed.
      r_we      <= w_found && (w_sel_reg != '0);
      if (w_found) begin
        r_last      <= w_gsel;
        r_grant_idx <= w_gsel;
        r_wreg      <= w_sel_reg;
        r_wdata     <= w_sel_data;
      end
    end
  end

  assign bus.req_ready        = w_grant & {NUM_REQ{ctrl_reset_n}};
  assign bus.ctrl_writeEnable = r_we;
  assign bus.ctrl_writeReg    = r_wreg;
  assign bus.data_writeReg    = r_wdata;
  assign bus.pending          = r_pending;
  assign bus.grant_idx        = r_grant_idx;

endmodule
